// File: rtl/clk_period_meter.sv
// Purpose: measure period and high time of a slow asynchronous square wave in clk_in cycles, check against expected values, report lock/timeout.
// Latency: 2-flop synchronizer plus edge flop; results are registered one cycle after the rise-detect cycle.
// Backpressure: none; meas_valid and timeout are single-cycle pulses that are not held for a consumer.
module clk_period_meter #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int EXP_HIGH   = 5,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_COUNT);
  localparam logic [MW-1:0]    MATCH_1 = MW'(1);
  localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_0   = '0;
  localparam logic [CNT_W-1:0] CNT_1   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [MW-1:0]    match_q, match_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             mv_q, mv_d;
  logic             locked_q, locked_d;
  logic             tmo_q, tmo_d;

  logic             rise;
  logic [CNT_W-1:0] per_diff, hi_diff;
  logic             match;
  logic [MW-1:0]    match_inc;

  // Bring sig_in into clk_in; s2 is the clean level, s3 only serves edge detection.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Compare the running counts against the expected values using unsigned absolute difference.
  always_comb begin
    per_diff  = (per_q >= EXP_P) ? (per_q - EXP_P) : (EXP_P - per_q);
    hi_diff   = (hi_q >= EXP_H) ? (hi_q - EXP_H) : (EXP_H - hi_q);
    match     = (per_diff <= TOL_C) && (hi_diff <= TOL_C);
    match_inc = (match_q == LOCK_M) ? match_q : (match_q + MATCH_1);
  end

  // Next-state logic: arm on the first rise, report on every later rise, give up after TIMEOUT cycles.
  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    match_d  = match_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    tmo_d    = 1'b0;
    locked_d = locked_q;
    case (state_q)
      IDLE: begin
        per_d = CNT_0;
        hi_d  = CNT_0;
        if (rise) begin
          per_d   = CNT_1;
          hi_d    = CNT_1;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          // The rise cycle itself is the first cycle of the next period (and is high).
          period_d = per_q;
          high_d   = hi_q;
          mv_d     = 1'b1;
          per_d    = CNT_1;
          hi_d     = CNT_1;
          if (match) begin
            match_d  = match_inc;
            locked_d = (match_inc == LOCK_M);
          end else begin
            match_d  = '0;
            locked_d = 1'b0;
          end
        end else if (per_q == TMO_C) begin
          tmo_d    = 1'b1;
          state_d  = IDLE;
          locked_d = 1'b0;
          match_d  = '0;
          per_d    = CNT_0;
          hi_d     = CNT_0;
        end else begin
          per_d = (per_q == CNT_MAX) ? per_q : (per_q + CNT_1);
          if (s2_q && (hi_q != CNT_MAX)) begin
            hi_d = hi_q + CNT_1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= IDLE;
      per_q    <= CNT_0;
      hi_q     <= CNT_0;
      match_q  <= '0;
      period_q <= CNT_0;
      high_q   <= CNT_0;
      mv_q     <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      match_q  <= match_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Purpose: directed bench for clk_period_meter: default, TOL=1 and TIMEOUT=32 instances.
// Latency: measurements checked per driven period; the rise that opens a period reports the previous one.
// Backpressure: not applicable.
module tb_clk_period_meter;

  logic        clk;
  logic        rst [3];
  logic        sig [3];
  logic [15:0] per_o [3];
  logic [15:0] hi_o [3];
  logic        mv [3];
  logic        lk [3];
  logic        to [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int overlap = 0;
  int to_cnt [3];
  int to_cyc [3];
  int mv_cyc [3];

  typedef struct {
    int inst;
    int per;
    int hi;
    bit lk;
  } meas_t;
  meas_t mq[$];

  typedef struct {
    int    inst;
    int    p;
    int    h;
    bit    emv;
    int    eper;
    int    ehi;
    bit    elk;
    string name;
  } row_t;
  row_t rows [24];

  clk_period_meter u_a (
    .clk_in(clk), .rst(rst[0]), .sig_in(sig[0]), .period_out(per_o[0]), .high_out(hi_o[0]),
    .meas_valid(mv[0]), .locked(lk[0]), .timeout(to[0]));

  clk_period_meter #(.TOL(1)) u_b (
    .clk_in(clk), .rst(rst[1]), .sig_in(sig[1]), .period_out(per_o[1]), .high_out(hi_o[1]),
    .meas_valid(mv[1]), .locked(lk[1]), .timeout(to[1]));

  clk_period_meter #(.TIMEOUT(32)) u_c (
    .clk_in(clk), .rst(rst[2]), .sig_in(sig[2]), .period_out(per_o[2]), .high_out(hi_o[2]),
    .meas_valid(mv[2]), .locked(lk[2]), .timeout(to[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every measurement and timeout pulse, sampled away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mv[i]) begin
        mq.push_back('{inst: i, per: int'(per_o[i]), hi: int'(hi_o[i]), lk: lk[i]});
        mv_cyc[i] = cyc;
      end
      if (to[i]) begin
        to_cnt[i] = to_cnt[i] + 1;
        to_cyc[i] = cyc;
      end
      if (mv[i] && to[i]) overlap = overlap + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_level(input int inst, input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      sig[inst] = lvl;
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one period (h high then p-h low); its opening rise must report the previous period.
  task automatic do_row(input int inst, input int p, input int h, input bit emv,
                        input int eper, input int ehi, input bit elk, input string name);
    int n0;
    int found;
    int idx;
    n0 = mq.size();
    drive_level(inst, 1'b1, h);
    drive_level(inst, 1'b0, p - h);
    found = 0;
    idx = -1;
    for (int i = n0; i < mq.size(); i++) begin
      if (mq[i].inst == inst) begin
        found++;
        idx = i;
      end
    end
    chk({name, " mv_count"}, found, emv ? 1 : 0);
    if (emv && idx >= 0) begin
      chk({name, " period_out"}, mq[idx].per, eper);
      chk({name, " high_out"}, mq[idx].hi, ehi);
      chk({name, " locked"}, int'(mq[idx].lk), int'(elk));
    end
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      do_row(rows[i].inst, rows[i].p, rows[i].h, rows[i].emv,
             rows[i].eper, rows[i].ehi, rows[i].elk, rows[i].name);
    end
  endtask

  initial begin
    int n0;
    int t0;
    // Instance A: lock on the divide-by-10 wave, break it with a 12/6 period, re-lock.
    rows[0]  = '{0, 10, 5, 0, 0, 0, 0, "A arm"};
    rows[1]  = '{0, 10, 5, 1, 10, 5, 0, "A m1"};
    rows[2]  = '{0, 10, 5, 1, 10, 5, 0, "A m2"};
    rows[3]  = '{0, 10, 5, 1, 10, 5, 0, "A m3"};
    rows[4]  = '{0, 10, 5, 1, 10, 5, 1, "A m4 lock"};
    rows[5]  = '{0, 10, 5, 1, 10, 5, 1, "A m5 hold"};
    rows[6]  = '{0, 12, 6, 1, 10, 5, 1, "A m6"};
    rows[7]  = '{0, 10, 5, 1, 12, 6, 0, "A stretch unlock"};
    rows[8]  = '{0, 10, 5, 1, 10, 5, 0, "A r1"};
    rows[9]  = '{0, 10, 5, 1, 10, 5, 0, "A r2"};
    rows[10] = '{0, 10, 5, 1, 10, 5, 0, "A r3"};
    rows[11] = '{0, 10, 5, 1, 10, 5, 1, "A r4 relock"};
    // Instance B (TOL=1): 11/6 is within tolerance, 12/5 is not.
    rows[12] = '{1, 11, 6, 0, 0, 0, 0, "B arm"};
    rows[13] = '{1, 11, 6, 1, 11, 6, 0, "B m1"};
    rows[14] = '{1, 11, 6, 1, 11, 6, 0, "B m2"};
    rows[15] = '{1, 11, 6, 1, 11, 6, 0, "B m3"};
    rows[16] = '{1, 11, 6, 1, 11, 6, 1, "B m4 lock"};
    rows[17] = '{1, 12, 5, 1, 11, 6, 1, "B m5"};
    rows[18] = '{1, 11, 6, 1, 12, 5, 0, "B 12/5 unlock"};
    // Instance C (TIMEOUT=32): reach lock before the stuck-low test.
    rows[19] = '{2, 10, 5, 0, 0, 0, 0, "C arm"};
    rows[20] = '{2, 10, 5, 1, 10, 5, 0, "C m1"};
    rows[21] = '{2, 10, 5, 1, 10, 5, 0, "C m2"};
    rows[22] = '{2, 10, 5, 1, 10, 5, 0, "C m3"};
    rows[23] = '{2, 10, 5, 1, 10, 5, 1, "C m4 lock"};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      sig[i] = 1'b0;
      to_cnt[i] = 0;
      to_cyc[i] = 0;
      mv_cyc[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset period_out", int'(per_o[0]), 0);
    chk("reset high_out", int'(hi_o[0]), 0);
    chk("reset meas_valid", int'(mv[0]), 0);
    chk("reset locked", int'(lk[0]), 0);
    chk("reset timeout", int'(to[0]), 0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    drive_level(0, 1'b0, 3);

    run_rows(0, 11);

    // Reset midway through a period while locked.
    drive_level(0, 1'b1, 5);
    drive_level(0, 1'b0, 2);
    chk("A locked before rst", int'(lk[0]), 1);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    chk("A rst period_out", int'(per_o[0]), 0);
    chk("A rst high_out", int'(hi_o[0]), 0);
    chk("A rst locked", int'(lk[0]), 0);
    chk("A rst mv/to", int'(mv[0]) + int'(to[0]), 0);
    drive_level(0, 1'b0, 3);
    do_row(0, 10, 5, 0, 0, 0, 0, "A post-rst arm");
    do_row(0, 10, 5, 1, 10, 5, 0, "A post-rst m1");
    do_row(0, 10, 5, 1, 10, 5, 0, "A post-rst m2");
    do_row(0, 10, 5, 1, 10, 5, 0, "A post-rst m3");
    do_row(0, 10, 5, 1, 10, 5, 1, "A post-rst m4");

    run_rows(12, 18);
    run_rows(19, 23);

    // Stuck low after lock: exactly one timeout, TIMEOUT cycles after the last meas_valid.
    n0 = mq.size();
    t0 = to_cnt[2];
    drive_level(2, 1'b0, 60);
    chk("C timeout pulses", to_cnt[2] - t0, 1);
    chk("C timeout delay", to_cyc[2] - mv_cyc[2], 32);
    chk("C no mv while stuck", mq.size() - n0, 0);
    chk("C locked after timeout", int'(lk[2]), 0);
    chk("C period_out kept", int'(per_o[2]), 10);

    // Restart: the first rise only re-arms; then a period of exactly TIMEOUT is measured.
    t0 = to_cnt[2];
    do_row(2, 10, 5, 0, 0, 0, 0, "C restart arm");
    do_row(2, 10, 5, 1, 10, 5, 0, "C restart m1");
    do_row(2, 32, 16, 1, 10, 5, 0, "C restart m2");
    do_row(2, 10, 5, 1, 32, 16, 0, "C period=TIMEOUT");
    chk("C no timeout at boundary", to_cnt[2] - t0, 0);

    chk("mv/timeout overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receive-side checker for divided clocks produced in the design, e.g. the 1 kHz output of the divide-by-10 stage.
- Samples a slow, asynchronous square wave `sig_in` in the `clk_in` domain.
- Measures its period and high time in `clk_in` cycles and compares both against expected values.
- Reports per-period measurements, a lock indication and a missing-edge timeout, for board bring-up and self-checking of divider chains.

Parameters:
- CNT_W, 16, width of the period and high-time counters and outputs.
- EXP_PERIOD, 10, expected period in `clk_in` cycles.
- EXP_HIGH, 5, expected high time in `clk_in` cycles.
- TOL, 0, allowed absolute deviation, applied to period and high time independently.
- LOCK_COUNT, 4, number of consecutive matching periods required for lock; must be at least 1.
- TIMEOUT, 1023, maximum period accepted before timeout; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk_in  input  1  sampling clock.
- rst  input  1  synchronous reset, active-high.
- sig_in  input  1  asynchronous signal under measurement.
- period_out  output  CNT_W  last measured period, in `clk_in` cycles.
- high_out  output  CNT_W  last measured high time, in `clk_in` cycles.
- meas_valid  output  1  one-cycle pulse when `period_out`/`high_out` update.
- locked  output  1  high after LOCK_COUNT consecutive matching periods.
- timeout  output  1  one-cycle pulse when no rising edge arrives within TIMEOUT cycles.

Behaviour:
- Reset and clock: reset `rst` is synchronous and active-high; clock is `clk_in`. While `rst`=1 at a `clk_in` edge:
  - Synchronizer flops s1, s2, s3 are cleared to 0.
  - State is IDLE.
  - per_cnt, hi_cnt and match_cnt are cleared to 0.
  - All outputs are cleared to 0.
- Synchronizer: s1<=sig_in, s2<=s1, s3<=s2. rise = s2 & ~s3. All counting uses s2, so the 2-cycle synchronizer latency cancels out of the measurements.
- Counters: per_cnt and hi_cnt saturate at 2^CNT_W-1. Comparisons use unsigned absolute difference.
- State IDLE:
  - per_cnt and hi_cnt are held at 0.
  - On rise: per_cnt<=1, hi_cnt<=1, go to MEASURE.
  - No meas_valid is produced, because no complete period has been seen.
- State MEASURE, on a cycle without rise:
  - per_cnt<=per_cnt+1.
  - hi_cnt<=hi_cnt+s2.
- State MEASURE, on rise:
  - period_out<=per_cnt and high_out<=hi_cnt.
  - meas_valid<=1 for one cycle.
  - per_cnt<=1, hi_cnt<=1, stay in MEASURE.
  - For a wave with period P and high time H (both in `clk_in` cycles), this yields period_out=P and high_out=H.
- Match and lock, evaluated in the same cycle as the rise, using per_cnt/hi_cnt:
  - match = |per_cnt-EXP_PERIOD|<=TOL and |hi_cnt-EXP_HIGH|<=TOL.
  - On match: match_cnt increments, saturating at LOCK_COUNT. locked<=1 once the new match_cnt equals LOCK_COUNT.
  - On mismatch: match_cnt<=0 and locked<=0. locked falls in the same cycle that meas_valid rises.
- Timeout:
  - Condition: in MEASURE, per_cnt==TIMEOUT and no rise.
  - Response: timeout<=1 for one cycle, state<=IDLE, locked<=0, match_cnt<=0. period_out and high_out keep their last values.
  - If rise occurs in the cycle where per_cnt==TIMEOUT, rise takes precedence: it is a valid measurement of period TIMEOUT.
- sig_in stuck high or stuck low produces no rises, so it ends in timeout.
- No timeout is generated in IDLE.
- Reset mid-measurement discards the partial period. The first rise after reset only arms MEASURE; the first meas_valid follows the second rise.
- Output timing: meas_valid, locked and timeout are registered. meas_valid and timeout are never high together.

Test Plan:
- Drive sig_in with a 10-cycle period, 5 cycles high (divide-by-10 waveform), defaults -> first meas_valid at the second detected rise with period_out=10, high_out=5. locked=1 coincident with the 4th meas_valid and stays 1.
- After lock, stretch one period to 12 cycles (6 high) -> that meas_valid shows period_out=12, high_out=6 and locked=0 in the same cycle. Re-lock occurs after 4 further correct periods.
- TOL=1 instance, periods of 11 cycles with 6 high -> every measurement matches; locked=1 at the 4th meas_valid. A 12-cycle period with 5 high -> mismatch, locked=0.
- TIMEOUT=32, lock achieved, then sig_in held low -> timeout=1 for exactly one cycle, TIMEOUT+1 cycles after the last rise-detect cycle. locked=0, no meas_valid, state IDLE. Restarting the 10-cycle wave gives a first meas_valid at the second rise.
- Period of exactly 32 cycles with TIMEOUT=32 -> meas_valid with period_out=32 and no timeout pulse.
- Assert rst for one cycle midway through a period while locked -> all outputs 0 the next cycle. The next rise gives no meas_valid; the following rise gives meas_valid with period_out=10, high_out=5, and locked=0 until 4 matches have been seen.
